// File: rtl/gm64_pkg.sv
//------------------------------------------------------------------------------
// gm64_pkg
// Shared gm64 types: CPU/memory bridge FSM states and the C64 colour palette.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package gm64_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REQ       = 3'd1,
        WAIT_DONE = 3'd2,
        DONE      = 3'd3,
        ERR       = 3'd4
    } bridge_state_t;

    typedef enum logic [3:0] {
        BLACK       = 4'h0,
        WHITE       = 4'h1,
        RED         = 4'h2,
        CYAN        = 4'h3,
        PURPLE      = 4'h4,
        GREEN       = 4'h5,
        BLUE        = 4'h6,
        YELLOW      = 4'h7,
        ORANGE      = 4'h8,
        BROWN       = 4'h9,
        LIGHT_RED   = 4'hA,
        DARK_GREY   = 4'hB,
        GREY        = 4'hC,
        LIGHT_GREEN = 4'hD,
        LIGHT_BLUE  = 4'hE,
        LIGHT_GREY  = 4'hF
    } color_t;

endpackage

`default_nettype wire

// File: rtl/sync2.sv
//------------------------------------------------------------------------------
// sync2
// Two-flop synchronizer into the clkPhi0 domain, async active-low reset.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clkPhi0,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;

    always_ff @(posedge clkPhi0 or negedge reset) begin
        if (!reset) begin
            r_meta <= '0;
            o_sync <= '0;
        end else begin
            r_meta <= i_async;
            o_sync <= r_meta;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cpu_mem_bridge.sv
//------------------------------------------------------------------------------
// cpu_mem_bridge
// Turns each 6502 bus cycle into one memCtrl request, stalling the CPU on RDY.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cpu_mem_bridge
    import gm64_pkg::*;
#(
    parameter logic [6:0]  BANK        = 7'd0,
    parameter int          TIMEOUT     = 1023,
    parameter logic [15:0] BORDER_ADDR = 16'hD020
) (
    input  logic        clkPhi0,
    input  logic        reset,
    input  logic [15:0] i_addr,
    input  logic [7:0]  i_cpu_do,
    input  logic        i_we,
    output logic [7:0]  o_cpu_di,
    output logic        o_rdy,
    output logic        o_ce,
    output logic        o_write,
    output logic [6:0]  o_bank,
    output logic [15:0] o_addr,
    output logic [7:0]  o_wdata,
    input  logic [7:0]  i_rdata,
    input  logic        i_busy,
    output color_t      o_border,
    output logic        o_timeout
);

    localparam int              CNT_W      = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_cnt_max  = CNT_W'(TIMEOUT);

    bridge_state_t    r_state;
    bridge_state_t    w_next;
    logic             w_busy_s;
    logic [CNT_W-1:0] r_cnt;
    logic             w_cnt_last;
    logic             w_in_phase;
    logic             w_enter_phase;

    sync2 #(
        .WIDTH (1)
    ) u_busy_sync (
        .clkPhi0 (clkPhi0),
        .reset   (reset),
        .i_async (i_busy),
        .o_sync  (w_busy_s)
    );

    assign o_bank        = BANK;
    assign w_cnt_last    = (r_cnt == c_cnt_last);
    assign w_in_phase    = (r_state == REQ) || (r_state == WAIT_DONE);
    assign w_enter_phase = (w_next != r_state) && ((w_next == REQ) || (w_next == WAIT_DONE));

    // A stale busy_s already high in REQ is taken as the acknowledge.
    always_comb begin
        w_next    = r_state;
        o_ce      = 1'b0;
        o_rdy     = 1'b0;
        o_timeout = 1'b0;
        unique case (r_state)
            IDLE: w_next = REQ;
            REQ: begin
                o_ce = 1'b1;
                if (w_busy_s)        w_next = WAIT_DONE;
                else if (w_cnt_last) w_next = ERR;
            end
            WAIT_DONE: begin
                if (!w_busy_s)       w_next = DONE;
                else if (w_cnt_last) w_next = ERR;
            end
            DONE: begin
                o_rdy  = 1'b1;
                w_next = IDLE;
            end
            ERR:     o_timeout = 1'b1;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clkPhi0 or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            o_addr   <= '0;
            o_write  <= 1'b0;
            o_wdata  <= '0;
            o_cpu_di <= '0;
            o_border <= BLACK;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE) begin
                o_addr  <= i_addr;
                o_write <= i_we;
                o_wdata <= i_cpu_do;
            end
            if (w_enter_phase)
                r_cnt <= '0;
            else if (w_in_phase && (r_cnt != c_cnt_max))
                r_cnt <= r_cnt + CNT_W'(1);
            if ((r_state == WAIT_DONE) && (w_next == DONE)) begin
                if (!o_write)
                    o_cpu_di <= i_rdata;
                else if (o_addr == BORDER_ADDR)
                    o_border <= color_t'(o_wdata[3:0]);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cpu_mem_bridge.sv
//------------------------------------------------------------------------------
// tb_cpu_mem_bridge
// Directed bench for cpu_mem_bridge with a simple memCtrl busy-handshake model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cpu_mem_bridge;

    logic        clkPhi0;
    logic        reset;
    logic [15:0] i_addr;
    logic [7:0]  i_cpu_do;
    logic        i_we;
    logic [7:0]  o_cpu_di;
    logic        o_rdy;
    logic        o_ce;
    logic        o_write;
    logic [6:0]  o_bank;
    logic [15:0] o_addr;
    logic [7:0]  o_wdata;
    logic [7:0]  i_rdata;
    logic        i_busy;
    logic [3:0]  o_border;
    logic        o_timeout;

    int n_checks = 0;
    int n_pass   = 0;

    // memCtrl model controls and monitor observations
    logic        mem_on = 1'b1;
    int          ce_pulses = 0;
    int          rdy_cycles = 0;
    logic        ce_prev = 1'b0;
    logic [15:0] cap_addr;
    logic        cap_write;
    logic [7:0]  cap_wdata;
    logic [6:0]  cap_bank;

    cpu_mem_bridge dut (
        .clkPhi0   (clkPhi0),
        .reset     (reset),
        .i_addr    (i_addr),
        .i_cpu_do  (i_cpu_do),
        .i_we      (i_we),
        .o_cpu_di  (o_cpu_di),
        .o_rdy     (o_rdy),
        .o_ce      (o_ce),
        .o_write   (o_write),
        .o_bank    (o_bank),
        .o_addr    (o_addr),
        .o_wdata   (o_wdata),
        .i_rdata   (i_rdata),
        .i_busy    (i_busy),
        .o_border  (o_border),
        .o_timeout (o_timeout)
    );

    initial clkPhi0 = 1'b0;
    always #5 clkPhi0 = ~clkPhi0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // memCtrl: busy rises one cycle after CE is seen, held for three cycles
    initial begin : mem_model
        int d;
        int h;
        d = 0;
        h = 0;
        i_busy = 1'b0;
        forever begin
            @(posedge clkPhi0);
            #1;
            if (!reset) begin
                i_busy = 1'b0;
                d = 0;
                h = 0;
            end else if (h > 0) begin
                h--;
                if (h == 0) i_busy = 1'b0;
            end else if (d > 0) begin
                d--;
                if (d == 0) begin
                    i_busy = 1'b1;
                    h = 3;
                end
            end else if (o_ce && mem_on) begin
                d = 1;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clkPhi0);
            if (o_ce && !ce_prev) begin
                ce_pulses++;
                cap_addr  = o_addr;
                cap_write = o_write;
                cap_wdata = o_wdata;
                cap_bank  = o_bank;
            end
            ce_prev = o_ce;
            if (o_rdy) rdy_cycles++;
        end
    end

    task automatic do_access(input string tag, input logic [15:0] a, input logic we,
                             input logic [7:0] wd, input logic [7:0] rd,
                             input logic [7:0] exp_di, input logic [3:0] exp_border);
        int n;
        i_addr     = a;
        i_we       = we;
        i_cpu_do   = wd;
        i_rdata    = rd;
        ce_pulses  = 0;
        rdy_cycles = 0;
        n = 0;
        @(negedge clkPhi0);
        while (!o_rdy && n < 50) begin
            @(negedge clkPhi0);
            n++;
        end
        chk({tag, ".rdy_seen"}, o_rdy, 1'b1);
        chk({tag, ".cpu_di"}, o_cpu_di, exp_di);
        chk({tag, ".border"}, o_border, exp_border);
        chk({tag, ".addr"}, cap_addr, a);
        chk({tag, ".write"}, cap_write, we);
        chk({tag, ".bank"}, cap_bank, 7'd0);
        if (we) chk({tag, ".wdata"}, cap_wdata, wd);
        @(negedge clkPhi0);
        #1;
        chk({tag, ".rdy_single"}, rdy_cycles, 1);
        chk({tag, ".rdy_low"}, o_rdy, 1'b0);
        chk({tag, ".ce_pulses"}, ce_pulses, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".ce"}, o_ce, 1'b0);
        chk({tag, ".rdy"}, o_rdy, 1'b0);
        chk({tag, ".write"}, o_write, 1'b0);
        chk({tag, ".addr"}, o_addr, 16'h0000);
        chk({tag, ".wdata"}, o_wdata, 8'h00);
        chk({tag, ".bank"}, o_bank, 7'd0);
        chk({tag, ".cpu_di"}, o_cpu_di, 8'h00);
        chk({tag, ".border"}, o_border, 4'h0);
        chk({tag, ".timeout"}, o_timeout, 1'b0);
    endtask

    initial begin : stim
        int n;
        int ce_cnt;
        reset    = 1'b0;
        i_addr   = 16'h0000;
        i_we     = 1'b0;
        i_cpu_do = 8'h00;
        i_rdata  = 8'h00;
        #12;
        chk_reset_vals("rst");
        @(negedge clkPhi0);
        #2 reset = 1'b1;

        do_access("read",   16'hC000, 1'b0, 8'h00, 8'hA9, 8'hA9, 4'h0);
        do_access("write",  16'h0400, 1'b1, 8'h55, 8'h11, 8'hA9, 4'h0);
        do_access("bwrite", 16'hD020, 1'b1, 8'hF2, 8'h22, 8'hA9, 4'h2);
        do_access("bread",  16'hD020, 1'b0, 8'h00, 8'h37, 8'h37, 4'h2);
        do_access("b2b0",   16'hFFFC, 1'b0, 8'h00, 8'h00, 8'h00, 4'h2);
        do_access("b2b1",   16'hFFFD, 1'b0, 8'h00, 8'hC0, 8'hC0, 4'h2);

        // reset while waiting for busy to fall
        i_addr  = 16'h8000;
        i_we    = 1'b0;
        i_rdata = 8'h77;
        n = 0;
        while (!o_ce && n < 20) begin
            @(negedge clkPhi0);
            n++;
        end
        while (o_ce && n < 40) begin
            @(negedge clkPhi0);
            n++;
        end
        chk("mid.in_wait", (n < 40) ? 1 : 0, 1);
        #2 reset = 1'b0;
        #1;
        chk_reset_vals("mid");
        rdy_cycles = 0;
        repeat (3) @(negedge clkPhi0);
        #2 reset = 1'b1;
        chk("mid.no_rdy", rdy_cycles, 0);
        do_access("fresh", 16'h1234, 1'b0, 8'h00, 8'h5A, 8'h5A, 4'h0);

        // memCtrl never answers
        mem_on  = 1'b0;
        i_addr  = 16'h2000;
        i_we    = 1'b0;
        n = 0;
        ce_cnt = 0;
        @(negedge clkPhi0);
        while (!o_timeout && n < 1100) begin
            if (o_ce) ce_cnt++;
            @(negedge clkPhi0);
            n++;
        end
        chk("to.req_cycles", ce_cnt, 1023);
        chk("to.flag", o_timeout, 1'b1);
        chk("to.ce", o_ce, 1'b0);
        rdy_cycles = 0;
        ce_cnt = 0;
        repeat (120) begin
            @(negedge clkPhi0);
            if (o_ce) ce_cnt++;
        end
        chk("to.rdy_frozen", rdy_cycles, 0);
        chk("to.ce_frozen", ce_cnt, 0);
        chk("to.sticky", o_timeout, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk_reset_vals("to_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
